branch_redirect_ctrl: RTL

BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

---
 rtl/branch_redirect_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
//   Turns a taken branch/jump resolved in EX into a redirect request to the
//   fetch unit. It flushes IF/ID and tracks outstanding fetches so that
//   wrong-path responses can be discarded after the redirect.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   ex_valid          : EX stage holds a valid instruction
//   branch_req/res    : conditional branch and its outcome (1 = taken)
//   jump_req          : JAL/JALR, always taken
//   target_addr       : resolved target PC
//   redir_valid/ready : redirect handshake to fetch; redir_pc is the target
//   flush_if/flush_id : kill IF/ID pipeline registers
//   fetch_hold        : fetch must not issue a request while high
//   ifetch_req_fire   : fetch request issued this cycle
//   ifetch_rsp_valid  : in-order fetch response returned this cycle
//   drop_rsp          : current response is wrong-path, discard it
//   excp_misalign     : one-cycle pulse, taken target not 4-byte aligned
module branch_redirect_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_OUT    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic                  branch_req,
  input  logic                  branch_res,
  input  logic                  jump_req,
  input  logic [ADDR_WIDTH-1:0] target_addr,
  output logic                  redir_valid,
  input  logic                  redir_ready,
  output logic [ADDR_WIDTH-1:0] redir_pc,
  output logic                  flush_if,
  output logic                  flush_id,
  output logic                  fetch_hold,
  input  logic                  ifetch_req_fire,
  input  logic                  ifetch_rsp_valid,
  output logic                  drop_rsp,
  output logic                  excp_misalign
);

  typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUT);

  state_t     state;
  logic [2:0] out_cnt, out_cnt_nxt;
  logic [2:0] stale_cnt, stale_dec;
  logic       taken, aligned, take_redir, in_redir;

  always_comb begin
    in_redir   = (state == REDIRECT);
    // Decisions are ignored while a redirect is already being handed over.
    taken      = !in_redir && ex_valid && (jump_req || (branch_req && branch_res));
    aligned    = (target_addr[1:0] == 2'b00);
    take_redir = taken && aligned;

    excp_misalign = taken && !aligned;
    flush_if      = in_redir || taken;
    flush_id      = in_redir || taken;
    redir_valid   = in_redir;
    fetch_hold    = in_redir || (out_cnt == MAX_CNT);

    // Responses return in order, so the stale ones are always the oldest.
    drop_rsp  = ifetch_rsp_valid && (stale_cnt != 3'd0);
    stale_dec = drop_rsp ? stale_cnt - 3'd1 : stale_cnt;

    // Saturating up/down counter; a simultaneous issue and return cancel.
    out_cnt_nxt = out_cnt;
    if (ifetch_req_fire && !ifetch_rsp_valid && out_cnt != 3'd7)
      out_cnt_nxt = out_cnt + 3'd1;
    else if (!ifetch_req_fire && ifetch_rsp_valid && out_cnt != 3'd0)
      out_cnt_nxt = out_cnt - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_cnt   <= 3'd0;
      stale_cnt <= 3'd0;
      redir_pc  <= '0;
    end else begin
      out_cnt <= out_cnt_nxt;
      case (state)
        REDIRECT: begin
          stale_cnt <= stale_dec;
          if (redir_ready)
            state <= (stale_dec == 3'd0) ? IDLE : DRAIN;
        end
        default: begin
          if (take_redir) begin
            // Everything still in flight, including a request issued this
            // cycle, belongs to the abandoned path.
            state     <= REDIRECT;
            redir_pc  <= target_addr;
            stale_cnt <= out_cnt_nxt;
          end else begin
            stale_cnt <= stale_dec;
            state     <= (stale_dec == 3'd0) ? IDLE : DRAIN;
          end
        end
      endcase
    end
  end

endmodule
